// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle RV32I control unit. Sequences fetch, decode,
//                execute, memory and writeback around an external ALU,
//                register file and a single valid/ready memory port.
//                Optional feature macro: CPU_ILLEGAL_TRAP_EN (illegal opcode
//                halts the core and raises a sticky trap).
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_op_a,
    output logic [31:0] alu_op_b,
    output logic [31:0] alu_pc,
    input  logic [31:0] alu_out,
    output logic        trap
);

    localparam logic [2:0] c_ST_FETCH   = 3'd0;
    localparam logic [2:0] c_ST_DECODE  = 3'd1;
    localparam logic [2:0] c_ST_EXECUTE = 3'd2;
    localparam logic [2:0] c_ST_MEM     = 3'd3;
    localparam logic [2:0] c_ST_WB      = 3'd4;
    localparam logic [2:0] c_ST_HALT    = 3'd5;

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_res;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_branch;
    logic        w_is_jump;
    logic        w_writes_rd;
    logic        w_handshake;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_b_imm;
    logic [31:0] w_pc_next;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [3:0]  w_store_strb;
    logic [31:0] w_store_data;

    assign w_opcode    = r_ir[6:0];
    assign w_funct3    = r_ir[14:12];
    assign w_is_load   = (w_opcode == c_OPC_LOAD);
    assign w_is_store  = (w_opcode == c_OPC_STORE);
    assign w_is_branch = (w_opcode == c_OPC_BRANCH);
    assign w_is_jump   = (w_opcode == c_OPC_JAL) || (w_opcode == c_OPC_JALR);
    assign w_writes_rd = w_is_load || w_is_jump ||
                         (w_opcode == c_OPC_OP) || (w_opcode == c_OPC_OP_IMM) ||
                         (w_opcode == c_OPC_LUI) || (w_opcode == c_OPC_AUIPC);
    assign w_handshake = mem_valid && mem_ready;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_b_imm     = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    // Jumps take the ALU target; branches use the ALU's one-bit decision
    assign w_pc_next   = w_is_jump ? r_res :
                         (w_is_branch && r_res[0]) ? (r_pc + w_b_imm) : w_pc_plus4;

    // The external ALU and register file always see registered values
    assign rs1_addr        = r_ir[19:15];
    assign rs2_addr        = r_ir[24:20];
    assign rd_addr         = r_ir[11:7];
    assign alu_instruction = r_ir;
    assign alu_op_a        = r_op_a;
    assign alu_op_b        = r_op_b;
    assign alu_pc          = r_pc;

    // Load lane extraction and sign/zero extension from the returned word
    always_comb begin
        w_half = r_res[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_res[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        case (w_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        case (w_funct3[1:0])
            2'b00: begin
                w_store_strb = 4'b0001 << r_res[1:0];
                w_store_data = {4{r_op_b[7:0]}};
            end
            2'b01: begin
                w_store_strb = 4'b0011 << {r_res[1], 1'b0};
                w_store_data = {2{r_op_b[15:0]}};
            end
            default: begin
                w_store_strb = 4'b1111;
                w_store_data = r_op_b;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= c_ST_FETCH;
        else          r_state <= w_state_next;
    end

`ifdef CPU_ILLEGAL_TRAP_EN
    logic w_legal;
    assign w_legal = (w_opcode == c_OPC_LOAD)   || (w_opcode == c_OPC_STORE)  ||
                     (w_opcode == c_OPC_OP)     || (w_opcode == c_OPC_OP_IMM) ||
                     (w_opcode == c_OPC_LUI)    || (w_opcode == c_OPC_AUIPC)  ||
                     (w_opcode == c_OPC_JAL)    || (w_opcode == c_OPC_JALR)   ||
                     (w_opcode == c_OPC_BRANCH) || (w_opcode == c_OPC_FENCE)  ||
                     (w_opcode == c_OPC_SYSTEM);
`endif

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_FETCH:   if (w_handshake) w_state_next = c_ST_DECODE;
            c_ST_DECODE:  w_state_next = c_ST_EXECUTE;
            c_ST_EXECUTE: begin
`ifdef CPU_ILLEGAL_TRAP_EN
                if (!w_legal)                       w_state_next = c_ST_HALT;
                else if (w_is_load || w_is_store)   w_state_next = c_ST_MEM;
                else                                w_state_next = c_ST_WB;
`else
                if (w_is_load || w_is_store)        w_state_next = c_ST_MEM;
                else                                w_state_next = c_ST_WB;
`endif
            end
            c_ST_MEM:     if (w_handshake) w_state_next = c_ST_WB;
            c_ST_WB:      w_state_next = c_ST_FETCH;
            c_ST_HALT:    w_state_next = c_ST_HALT;
            default:      w_state_next = c_ST_FETCH;
        endcase
    end

    // Bus and writeback outputs; the request drops as soon as reset asserts
    always_comb begin
        mem_valid = reset_n && ((r_state == c_ST_FETCH) || (r_state == c_ST_MEM));
        mem_addr  = r_pc;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        rd_we     = 1'b0;
        rd_wdata  = 32'd0;
        case (r_state)
            c_ST_MEM: begin
                mem_addr = {r_res[31:2], 2'b00};
                if (w_is_store) begin
                    mem_wstrb = w_store_strb;
                    mem_wdata = w_store_data;
                end
            end
            c_ST_WB: begin
                if (w_writes_rd) begin
                    rd_we    = (r_ir[11:7] != 5'd0);
                    rd_wdata = w_is_jump ? w_pc_plus4 : r_res;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers: pc, instruction, operands and result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc   <= RESET_PC;
            r_ir   <= 32'd0;
            r_op_a <= 32'd0;
            r_op_b <= 32'd0;
            r_res  <= 32'd0;
        end else begin
            case (r_state)
                c_ST_FETCH:   if (w_handshake) r_ir <= mem_rdata;
                c_ST_DECODE: begin
                    r_op_a <= rs1_data;
                    r_op_b <= rs2_data;
                end
                c_ST_EXECUTE: r_res <= alu_out;
                c_ST_MEM:     if (w_handshake && w_is_load) r_res <= w_load_data;
                c_ST_WB:      r_pc <= w_pc_next;
                default: ;
            endcase
        end
    end

`ifdef CPU_ILLEGAL_TRAP_EN
    logic r_trap;
    // Sticky trap flag, set when an illegal opcode reaches execute
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                  r_trap <= 1'b0;
        else if ((r_state == c_ST_EXECUTE) && !w_legal) r_trap <= 1'b1;
    end
    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Scoreboard bench for cpu_sequencer with a behavioural ALU,
//                register file and memory. Expected bus transfers and
//                register writes are queued by the stimulus and consumed by
//                an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] alu_instruction, alu_op_a, alu_op_b, alu_pc, alu_out;
    logic        trap;

    cpu_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .alu_instruction(alu_instruction), .alu_op_a(alu_op_a),
        .alu_op_b(alu_op_b), .alu_pc(alu_pc), .alu_out(alu_out),
        .trap(trap)
    );

    always #5 clk = ~clk;

    // Behavioural ALU for the subset of instructions used below
    function automatic logic [31:0] alu_model(input logic [31:0] i, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] pc);
        logic [31:0] imm_i, imm_s, imm_j;
        imm_i = {{20{i[31]}}, i[31:20]};
        imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
        imm_j = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        case (i[6:0])
            7'b0110111: return {i[31:12], 12'd0};
            7'b0010111: return pc + {i[31:12], 12'd0};
            7'b1101111: return pc + imm_j;
            7'b1100111: return (a + imm_i) & 32'hFFFF_FFFE;
            7'b0000011: return a + imm_i;
            7'b0100011: return a + imm_s;
            7'b0010011: return a + imm_i;
            7'b0110011: return i[30] ? a - b : a + b;
            7'b1100011: begin
                case (i[14:12])
                    3'b000:  return {31'd0, a == b};
                    3'b001:  return {31'd0, a != b};
                    3'b100:  return {31'd0, $signed(a) < $signed(b)};
                    3'b101:  return {31'd0, $signed(a) >= $signed(b)};
                    3'b110:  return {31'd0, a < b};
                    default: return {31'd0, a >= b};
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction
    assign alu_out = alu_model(alu_instruction, alu_op_a, alu_op_b, alu_pc);

    // Register file model: combinational read, write on the rd_we edge
    logic [31:0] rf [32];
    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];
    always @(posedge clk) if (rd_we && rd_addr != 5'd0) rf[rd_addr] <= rd_wdata;

    logic [31:0] mem [logic [31:0]];

    typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;
    typedef struct { logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; int gap; } bus_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

    chk_t dq[$];
    bus_t bus_q[$];
    wb_t  wb_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs = 0;
    chk_t mon_c;
    bus_t mon_b;
    wb_t  mon_w;

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // Monitor: consumes queued expectations whenever the DUT presents activity
    always @(negedge clk) begin
        cyc++;
        while (dq.size() > 0) begin
            mon_c = dq.pop_front();
            cmp(mon_c.name, mon_c.act, mon_c.exp);
        end
        if (reset_n && mem_valid) begin
            if (bus_q.size() == 0) begin
                if (mem_ready) cmp("unexpected_xfer_addr", mem_addr, 32'hDEAD_BEEF);
            end else begin
                mon_b = bus_q[0];
                cmp("bus_addr", mem_addr, mon_b.addr);
                cmp("bus_wstrb", {28'd0, mem_wstrb}, {28'd0, mon_b.wstrb});
                if (mon_b.wstrb != 4'd0) cmp("bus_wdata", mem_wdata, mon_b.wdata);
                if (mem_ready) begin
                    void'(bus_q.pop_front());
                    if (mon_b.gap != 0) cmp("xfer_gap", cyc - last_hs, mon_b.gap);
                end
            end
            if (mem_ready) last_hs = cyc;
        end
        if (reset_n && rd_we) begin
            if (wb_q.size() == 0) begin
                cmp("unexpected_wb_rd", {27'd0, rd_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_w = wb_q.pop_front();
                cmp("wb_rd", {27'd0, rd_addr}, {27'd0, mon_w.rd});
                cmp("wb_data", rd_wdata, mon_w.data);
            end
        end
    end

    int  waited = 0;
    int  store_stall = 3;
    bit  hold = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = n; c.act = a; c.exp = e;
        dq.push_back(c);
    endtask

    task automatic exp_bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int g);
        bus_t b;
        b.addr = a; b.wstrb = s; b.wdata = d; b.gap = g;
        bus_q.push_back(b);
    endtask

    task automatic exp_wb(input logic [4:0] r, input logic [31:0] d);
        wb_t w;
        w.rd = r; w.data = d;
        wb_q.push_back(w);
    endtask

    // Memory responder, called once per cycle just after the rising edge
    task automatic drive();
        if (!mem_valid || hold) begin
            mem_ready = 1'b0;
        end else if (mem_wstrb != 4'd0 && waited < store_stall) begin
            mem_ready = 1'b0;
            waited++;
        end else begin
            mem_ready = 1'b1;
            waited = 0;
        end
        mem_rdata = (mem_valid && mem.exists(mem_addr)) ? mem[mem_addr] : 32'd0;
    endtask

    task automatic run_until_drained(input int budget);
        int n;
        drive();
        for (n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            if (bus_q.size() == 0 && wb_q.size() == 0) break;
            drive();
        end
        if (n == budget) begin
            chk("timeout", 32'd1, 32'd0);
            bus_q.delete();
            wb_q.delete();
        end
        hold = 1'b1;
        drive();
        repeat (3) begin
            @(posedge clk); #1;
            drive();
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        hold = 1'b0;
        waited = 0;
        reset_n = 1'b1;
        #1;
        chk("valid_after_reset", {31'd0, mem_valid}, 32'd1);
        chk("addr_after_reset", mem_addr, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_rd_we", {31'd0, rd_we}, 32'd0);
        chk("rst_rd_wdata", rd_wdata, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_alu_instr", alu_instruction, 32'd0);
        chk("rst_alu_pc", alu_pc, 32'd0);

        // Program 1: ALU ops, branches, loads, stalled store, jumps
        mem[32'h00] = 32'h0050_0093;  // ADDI x1,x0,5
        mem[32'h04] = 32'h1000_0113;  // ADDI x2,x0,0x100
        mem[32'h08] = 32'h1234_52B7;  // LUI  x5,0x12345
        mem[32'h0C] = 32'h6AB2_8293;  // ADDI x5,x5,0x6AB
        mem[32'h10] = 32'h0000_0463;  // BEQ  x0,x0,+8
        mem[32'h14] = 32'h0070_0093;  // ADDI x1,x0,7 (must be skipped)
        mem[32'h18] = 32'h0000_1463;  // BNE  x0,x0,+8
        mem[32'h1C] = 32'h0021_0183;  // LB   x3,2(x2)
        mem[32'h20] = 32'h0021_4183;  // LBU  x3,2(x2)
        mem[32'h24] = 32'h0021_1183;  // LH   x3,2(x2)
        mem[32'h28] = 32'h0051_00A3;  // SB   x5,1(x2)
        mem[32'h2C] = 32'h0100_00EF;  // JAL  x1,+16
        mem[32'h3C] = 32'h0000_006F;  // JAL  x0,+0
        mem[32'h100] = 32'h80FF_0000;

        exp_bus(32'h00, 4'd0, 32'd0, 0); exp_wb(5'd1, 32'd5);
        exp_bus(32'h04, 4'd0, 32'd0, 4); exp_wb(5'd2, 32'h100);
        exp_bus(32'h08, 4'd0, 32'd0, 4); exp_wb(5'd5, 32'h1234_5000);
        exp_bus(32'h0C, 4'd0, 32'd0, 4); exp_wb(5'd5, 32'h1234_56AB);
        exp_bus(32'h10, 4'd0, 32'd0, 4);
        exp_bus(32'h18, 4'd0, 32'd0, 4);
        exp_bus(32'h1C, 4'd0, 32'd0, 4);
        exp_bus(32'h100, 4'd0, 32'd0, 3); exp_wb(5'd3, 32'hFFFF_FFFF);
        exp_bus(32'h20, 4'd0, 32'd0, 2);
        exp_bus(32'h100, 4'd0, 32'd0, 3); exp_wb(5'd3, 32'h0000_00FF);
        exp_bus(32'h24, 4'd0, 32'd0, 2);
        exp_bus(32'h100, 4'd0, 32'd0, 3); exp_wb(5'd3, 32'hFFFF_80FF);
        exp_bus(32'h28, 4'd0, 32'd0, 2);
        exp_bus(32'h100, 4'b0010, 32'hABAB_ABAB, 6);
        exp_bus(32'h2C, 4'd0, 32'd0, 2); exp_wb(5'd1, 32'h30);
        exp_bus(32'h3C, 4'd0, 32'd0, 4);
        exp_bus(32'h3C, 4'd0, 32'd0, 4);

        release_reset();
        run_until_drained(300);
        chk("loop_fetch_valid", {31'd0, mem_valid}, 32'd1);
        chk("loop_fetch_addr", mem_addr, 32'h3C);

        // Reset in the middle of a pending fetch drops the request at once
        reset_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, mem_valid}, 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_rd_we", {31'd0, rd_we}, 32'd0);

        // Program 2: illegal opcode behaviour
        mem[32'h00] = 32'hFFFF_FFFF;
        mem[32'h04] = 32'h0050_0093;  // ADDI x1,x0,5
        mem[32'h08] = 32'h0000_006F;  // JAL  x0,+0
        exp_bus(32'h00, 4'd0, 32'd0, 0);
`ifndef CPU_ILLEGAL_TRAP_EN
        exp_bus(32'h04, 4'd0, 32'd0, 4); exp_wb(5'd1, 32'd5);
        exp_bus(32'h08, 4'd0, 32'd0, 4);
`endif
        release_reset();
        run_until_drained(100);
`ifdef CPU_ILLEGAL_TRAP_EN
        chk("halt_trap", {31'd0, trap}, 32'd1);
        chk("halt_valid", {31'd0, mem_valid}, 32'd0);
        hold = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            drive();
        end
        chk("halt_trap_sticky", {31'd0, trap}, 32'd1);
        chk("halt_valid_stays", {31'd0, mem_valid}, 32'd0);
`else
        chk("nop_trap", {31'd0, trap}, 32'd0);
        chk("nop_valid", {31'd0, mem_valid}, 32'd1);
        chk("nop_addr", mem_addr, 32'h08);
`endif
        reset_n = 1'b0;
        #1;
        chk("final_rst_trap", {31'd0, trap}, 32'd0);
        chk("final_rst_valid", {31'd0, mem_valid}, 32'd0);
        release_reset();
        hold = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the RV32I core that sequences the shared combinational ALU, the register file and a single valid/ready memory port through fetch, decode, execute, memory and writeback phases. It owns the program counter and the instruction register, presents the latched instruction and operands to the ALU, and interprets the ALU result as a data value, an effective address, a jump target or a branch decision. It sits between the core top level, the register file and the memory bus adapter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned
- clk  in  1  core clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- mem_valid  out  1  memory request pending
- mem_ready  in  1  memory accepts the request, and returns read data for reads, in this cycle
- mem_addr  out  32  word address, low 2 bits always 0
- mem_wstrb  out  4  byte write enables; 0 for reads
- mem_wdata  out  32  store data, placed in the addressed byte lanes
- mem_rdata  in  32  read data, valid when mem_valid && mem_ready
- rs1_addr, rs2_addr  out  5 each  register file read addresses; read is combinational
- rs1_data, rs2_data  in  32 each  register file read data
- rd_we  out  1  register write enable, one-cycle pulse
- rd_addr  out  5  destination register
- rd_wdata  out  32  writeback data
- alu_instruction, alu_op_a, alu_op_b, alu_pc  out  32 each  ALU inputs
- alu_out  in  32  ALU result
- trap  out  1  sticky; set on an illegal instruction when CPU_ILLEGAL_TRAP_EN is defined

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH: mem_valid=1, mem_addr=pc, mem_wstrb=0. On a handshake, latch mem_rdata into ir and go to DECODE.
- DECODE: rs1_addr=ir[19:15] and rs2_addr=ir[24:20]. Latch rs1_data and rs2_data into op_a and op_b. Go to EXECUTE.
- EXECUTE: ALU inputs are ir, op_a, op_b and pc. Latch alu_out into res. LOAD and STORE go to MEM; every other opcode goes to WRITEBACK.
- MEM: mem_addr={res[31:2],2'b00}.
  - Loads: mem_wstrb=0.
  - Stores: SB drives mem_wstrb=4'b0001<<res[1:0] and replicates op_b[7:0] across all lanes. SH drives 4'b0011<<{res[1],1'b0} and replicates op_b[15:0]. SW drives 4'b1111.
  - On a handshake, a load extracts its lane (LB and LBU use res[1:0]; LH and LHU use res[1]; LW ignores low bits), then sign- or zero-extends it into res. Go to WRITEBACK.
- WRITEBACK, by opcode:
  - OP, OP_IMM, LUI, AUIPC, LOAD: rd_wdata=res.
  - JAL, JALR: rd_wdata=pc+4, then pc←res.
  - BRANCH: pc←pc+B_imm if res[0], else pc+4.
  - All other opcodes: pc←pc+4.
  - STORE and BRANCH never write a register.
  - rd_we=1 only if the opcode writes and ir[11:7]≠0. Go to FETCH.
- Misaligned accesses are not detected; the lane rules above apply.
- Illegal opcode (not one of the 11 RV32I base opcodes; FENCE and SYSTEM are treated as NOP): see Configuration.
- The ALU inputs are driven in every state from registered values, so alu_out is deterministic at all times.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=FETCH, pc=RESET_PC, ir=0, trap=0.
  - mem_valid=0, mem_wstrb=0, rd_we=0.
  - All data outputs are 0; mem_addr=RESET_PC.
- mem_valid rises combinationally in the first FETCH cycle after reset_n deasserts.
- Handshake rules:
  - A transfer occurs on a rising edge where mem_valid && mem_ready.
  - Once mem_valid is raised, mem_addr, mem_wstrb and mem_wdata stay stable until that transfer.
  - mem_valid drops in the cycle after the transfer.
  - mem_ready while mem_valid=0 is ignored.
- Latency, where Wf and Wm are the cycles spent waiting for mem_ready in fetch and memory access:
  - ALU, branch and jump instructions: 4+Wf cycles.
  - Loads and stores: 5+Wf+Wm cycles.
- rd_we is high for exactly one cycle, in WRITEBACK; the register file commits on that edge.
- A reset during FETCH or MEM abandons the request, and mem_valid falls asynchronously. The bus is required to tolerate a dropped request.

## Configuration
- CPU_ILLEGAL_TRAP_EN defined: an illegal opcode in EXECUTE goes to HALT instead of MEM or WRITEBACK.
  - trap=1, with no register write and no PC update.
  - HALT is left only by reset.
- Not defined: an illegal opcode executes as a NOP (pc←pc+4, no writes) and trap is tied to 0.

## Test plan
- ADDI x1,x0,5 (32'h00500093) at RESET_PC=0, with mem_ready tied high → rd_we pulses with rd_addr=1 and rd_wdata=5 in cycle 4; the next fetch is at mem_addr=4.
- BEQ x0,x0,+8 (32'h00000463) at pc=0x10 → no rd_we pulse; the next fetch is at 0x18. The same test with BNE (32'h00001463) → next fetch at 0x14.
- Set x2=0x100 and hold mem_rdata=32'h80FF_0000. Issue LB x3,2(x2) → mem_addr=0x100 and rd_wdata=32'hFFFF_FFFF; LBU → 32'h0000_00FF; LH at offset 2 → 32'hFFFF_80FF.
- Set x2=0x100 and x5=0x1234_56AB. Issue SB x5,1(x2) → mem_wstrb=4'b0010, mem_wdata[15:8]=8'hAB, mem_addr=0x100. Hold mem_ready low for 3 cycles → mem_addr, mem_wstrb and mem_wdata stay stable; total latency is 8 cycles.
- JAL x0,+0 at pc=0x20 → no rd_we pulse and the next fetch is at 0x20. JAL x1,+16 → rd_wdata=0x24 and the next fetch is at 0x30.
- Fetch 32'hFFFF_FFFF:
  - With CPU_ILLEGAL_TRAP_EN: trap=1, mem_valid stays 0 from then on, and asserting reset_n low clears both.
  - Without it: the next fetch is at pc+4 and trap stays 0.
